// File: rtl/ysyx_24080006_axi_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_xbar_pkg
// Brief    : Shared types and constants for the 1-to-N AXI address router.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24080006_xbar_pkg;

  localparam int XBAR_MAX_SUB = 8;
  localparam int XBAR_IDX_W   = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_ERR  = 2'd3
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    W_ERR  = 3'd4
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_24080006_axi_xbar_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_axi
// Brief    : AXI4 bundle, 32-bit data, 4-bit ID, with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24080006_axi;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_24080006_axi_xbar_decode.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_xbar_decode
// Brief    : Address to {hit, index} decoder; highest matching index wins.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080006_xbar_decode
  import ysyx_24080006_xbar_pkg::*;
#(
  parameter int                      N_SUB = 2,
  parameter logic [N_SUB-1:0][31:0]  BASE  = {32'h0200_0000, 32'h0000_0000},
  parameter logic [N_SUB-1:0][31:0]  MASK  = {32'hFFFF_0000, 32'h0000_0000}
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [XBAR_IDX_W-1:0] idx
);

  logic [XBAR_MAX_SUB-1:0] w_match;

  // Per-port match vector, padded to the maximum port count with zeros.
  for (genvar g = 0; g < XBAR_MAX_SUB; g++) begin : g_match
    if (g < N_SUB) begin : g_live
      assign w_match[g] = ((addr & MASK[g]) == (BASE[g] & MASK[g]));
    end else begin : g_none
      assign w_match[g] = 1'b0;
    end
  end

  // Priority pick: later (higher) indices override earlier matches.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < XBAR_MAX_SUB; i++) begin
      if (w_match[i]) begin
        hit = 1'b1;
        idx = XBAR_IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080006_axi_xbar.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_axi_xbar
// Brief    : 1-to-N AXI4 address router with internal DECERR responder.
//            Independent single-outstanding read and write FSMs.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080006_axi_xbar
  import ysyx_24080006_xbar_pkg::*;
#(
  parameter int                      N_SUB = 2,
  parameter logic [N_SUB-1:0][31:0]  BASE  = {32'h0200_0000, 32'h0000_0000},
  parameter logic [N_SUB-1:0][31:0]  MASK  = {32'hFFFF_0000, 32'h0000_0000}
) (
  input  logic             clock,
  input  logic             reset,
  ysyx_24080006_axi.slave  axi,
  ysyx_24080006_axi.master axi_sub [N_SUB]
);

  // Downstream responses gathered into fixed-size arrays so the latched
  // 3-bit index can select them directly; absent ports read as zero.
  logic [XBAR_MAX_SUB-1:0]       w_sub_arready, w_sub_rvalid, w_sub_rlast;
  logic [XBAR_MAX_SUB-1:0][31:0] w_sub_rdata;
  logic [XBAR_MAX_SUB-1:0][1:0]  w_sub_rresp, w_sub_bresp;
  logic [XBAR_MAX_SUB-1:0][3:0]  w_sub_rid, w_sub_bid;
  logic [XBAR_MAX_SUB-1:0]       w_sub_awready, w_sub_wready, w_sub_bvalid;

  logic                  w_ar_hit, w_aw_hit;
  logic [XBAR_IDX_W-1:0] w_ar_idx, w_aw_idx;

  rd_state_e             r_rd_state, w_rd_next;
  logic [31:0]           r_ar_addr;
  logic [3:0]            r_ar_id;
  logic [7:0]            r_ar_len;
  logic [2:0]            r_ar_size;
  logic [1:0]            r_ar_burst;
  logic [XBAR_IDX_W-1:0] r_rd_idx;
  logic [7:0]            r_err_cnt;

  wr_state_e             r_wr_state, w_wr_next;
  logic [31:0]           r_aw_addr;
  logic [3:0]            r_aw_id;
  logic [7:0]            r_aw_len;
  logic [2:0]            r_aw_size;
  logic [1:0]            r_aw_burst;
  logic [XBAR_IDX_W-1:0] r_wr_idx;
  logic                  r_werr_resp;

  ysyx_24080006_xbar_decode #(.N_SUB(N_SUB), .BASE(BASE), .MASK(MASK)) u_ar_dec (
    .addr (axi.araddr),
    .hit  (w_ar_hit),
    .idx  (w_ar_idx)
  );

  ysyx_24080006_xbar_decode #(.N_SUB(N_SUB), .BASE(BASE), .MASK(MASK)) u_aw_dec (
    .addr (axi.awaddr),
    .hit  (w_aw_hit),
    .idx  (w_aw_idx)
  );

  // Read path: state register, request latch and error-beat down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_ar_addr  <= '0;
      r_ar_id    <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_rd_idx   <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == R_IDLE && axi.arvalid) begin
        r_ar_addr  <= axi.araddr;
        r_ar_id    <= axi.arid;
        r_ar_len   <= axi.arlen;
        r_ar_size  <= axi.arsize;
        r_ar_burst <= axi.arburst;
        r_rd_idx   <= w_ar_idx;
        r_err_cnt  <= axi.arlen;
      end else if (r_rd_state == R_ERR && axi.rready && r_err_cnt != 8'd0) begin
        r_err_cnt <= r_err_cnt - 8'd1;
      end
    end
  end

  // Read path next-state.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE: if (axi.arvalid) w_rd_next = w_ar_hit ? R_ADDR : R_ERR;
      R_ADDR: if (w_sub_arready[r_rd_idx]) w_rd_next = R_DATA;
      R_DATA: if (w_sub_rvalid[r_rd_idx] && axi.rready && w_sub_rlast[r_rd_idx])
                w_rd_next = R_IDLE;
      R_ERR:  if (axi.rready && r_err_cnt == 8'd0) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Upstream AR/R outputs: pass-through in R_DATA, synthesized DECERR in R_ERR.
  always_comb begin
    axi.arready = (r_rd_state == R_IDLE);
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rid     = '0;
    case (r_rd_state)
      R_DATA: begin
        axi.rvalid = w_sub_rvalid[r_rd_idx];
        axi.rdata  = w_sub_rdata[r_rd_idx];
        axi.rresp  = w_sub_rresp[r_rd_idx];
        axi.rlast  = w_sub_rlast[r_rd_idx];
        axi.rid    = w_sub_rid[r_rd_idx];
      end
      R_ERR: begin
        axi.rvalid = 1'b1;
        axi.rresp  = RESP_DECERR;
        axi.rlast  = (r_err_cnt == 8'd0);
        axi.rid    = r_ar_id;
      end
      default: ;
    endcase
  end

  // Write path: state register, request latch and DECERR response flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_state  <= W_IDLE;
      r_aw_addr   <= '0;
      r_aw_id     <= '0;
      r_aw_len    <= '0;
      r_aw_size   <= '0;
      r_aw_burst  <= '0;
      r_wr_idx    <= '0;
      r_werr_resp <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      if (r_wr_state == W_IDLE && axi.awvalid) begin
        r_aw_addr   <= axi.awaddr;
        r_aw_id     <= axi.awid;
        r_aw_len    <= axi.awlen;
        r_aw_size   <= axi.awsize;
        r_aw_burst  <= axi.awburst;
        r_wr_idx    <= w_aw_idx;
        r_werr_resp <= 1'b0;
      end else if (r_wr_state == W_ERR && !r_werr_resp && axi.wvalid && axi.wlast) begin
        r_werr_resp <= 1'b1;
      end
    end
  end

  // Write path next-state.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: if (axi.awvalid) w_wr_next = w_aw_hit ? W_ADDR : W_ERR;
      W_ADDR: if (w_sub_awready[r_wr_idx]) w_wr_next = W_DATA;
      W_DATA: if (axi.wvalid && w_sub_wready[r_wr_idx] && axi.wlast) w_wr_next = W_RESP;
      W_RESP: if (w_sub_bvalid[r_wr_idx] && axi.bready) w_wr_next = W_IDLE;
      W_ERR:  if (r_werr_resp && axi.bready) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Upstream AW/W/B outputs; W_ERR swallows beats, then answers DECERR.
  always_comb begin
    axi.awready = (r_wr_state == W_IDLE);
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = '0;
    axi.bid     = '0;
    case (r_wr_state)
      W_DATA: axi.wready = w_sub_wready[r_wr_idx];
      W_RESP: begin
        axi.bvalid = w_sub_bvalid[r_wr_idx];
        axi.bresp  = w_sub_bresp[r_wr_idx];
        axi.bid    = w_sub_bid[r_wr_idx];
      end
      W_ERR: begin
        if (r_werr_resp) begin
          axi.bvalid = 1'b1;
          axi.bresp  = RESP_DECERR;
          axi.bid    = r_aw_id;
        end else begin
          axi.wready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Per-port steering: only the selected port sees valids/readies/payload.
  for (genvar g = 0; g < XBAR_MAX_SUB; g++) begin : g_port
    if (g < N_SUB) begin : g_live
      localparam logic [XBAR_IDX_W-1:0] C_IDX = XBAR_IDX_W'(g);
      logic w_ar_sel, w_r_sel, w_aw_sel, w_w_sel, w_b_sel;
      assign w_ar_sel = (r_rd_state == R_ADDR) && (r_rd_idx == C_IDX);
      assign w_r_sel  = (r_rd_state == R_DATA) && (r_rd_idx == C_IDX);
      assign w_aw_sel = (r_wr_state == W_ADDR) && (r_wr_idx == C_IDX);
      assign w_w_sel  = (r_wr_state == W_DATA) && (r_wr_idx == C_IDX);
      assign w_b_sel  = (r_wr_state == W_RESP) && (r_wr_idx == C_IDX);

      assign axi_sub[g].arvalid = w_ar_sel;
      assign axi_sub[g].araddr  = w_ar_sel ? r_ar_addr  : '0;
      assign axi_sub[g].arid    = w_ar_sel ? r_ar_id    : '0;
      assign axi_sub[g].arlen   = w_ar_sel ? r_ar_len   : '0;
      assign axi_sub[g].arsize  = w_ar_sel ? r_ar_size  : '0;
      assign axi_sub[g].arburst = w_ar_sel ? r_ar_burst : '0;
      assign axi_sub[g].rready  = w_r_sel & axi.rready;

      assign axi_sub[g].awvalid = w_aw_sel;
      assign axi_sub[g].awaddr  = w_aw_sel ? r_aw_addr  : '0;
      assign axi_sub[g].awid    = w_aw_sel ? r_aw_id    : '0;
      assign axi_sub[g].awlen   = w_aw_sel ? r_aw_len   : '0;
      assign axi_sub[g].awsize  = w_aw_sel ? r_aw_size  : '0;
      assign axi_sub[g].awburst = w_aw_sel ? r_aw_burst : '0;
      assign axi_sub[g].wvalid  = w_w_sel & axi.wvalid;
      assign axi_sub[g].wdata   = w_w_sel ? axi.wdata : '0;
      assign axi_sub[g].wstrb   = w_w_sel ? axi.wstrb : '0;
      assign axi_sub[g].wlast   = w_w_sel & axi.wlast;
      assign axi_sub[g].bready  = w_b_sel & axi.bready;

      assign w_sub_arready[g] = axi_sub[g].arready;
      assign w_sub_rvalid[g]  = axi_sub[g].rvalid;
      assign w_sub_rdata[g]   = axi_sub[g].rdata;
      assign w_sub_rresp[g]   = axi_sub[g].rresp;
      assign w_sub_rlast[g]   = axi_sub[g].rlast;
      assign w_sub_rid[g]     = axi_sub[g].rid;
      assign w_sub_awready[g] = axi_sub[g].awready;
      assign w_sub_wready[g]  = axi_sub[g].wready;
      assign w_sub_bvalid[g]  = axi_sub[g].bvalid;
      assign w_sub_bresp[g]   = axi_sub[g].bresp;
      assign w_sub_bid[g]     = axi_sub[g].bid;
    end else begin : g_tie
      assign w_sub_arready[g] = 1'b0;
      assign w_sub_rvalid[g]  = 1'b0;
      assign w_sub_rdata[g]   = '0;
      assign w_sub_rresp[g]   = '0;
      assign w_sub_rlast[g]   = 1'b0;
      assign w_sub_rid[g]     = '0;
      assign w_sub_awready[g] = 1'b0;
      assign w_sub_wready[g]  = 1'b0;
      assign w_sub_bvalid[g]  = 1'b0;
      assign w_sub_bresp[g]   = '0;
      assign w_sub_bid[g]     = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_axi_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24080006_axi_xbar
// Brief    : Directed self-checking bench for the AXI address router, using
//            a 2-port default instance and a 1-port DECERR instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080006_axi_xbar;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  ysyx_24080006_axi up2 ();
  ysyx_24080006_axi sub2 [2] ();
  ysyx_24080006_axi up1 ();
  ysyx_24080006_axi sub1 [1] ();

  ysyx_24080006_axi_xbar u_dut2 (
    .clock   (clock),
    .reset   (reset),
    .axi     (up2),
    .axi_sub (sub2)
  );

  ysyx_24080006_axi_xbar #(
    .N_SUB (1),
    .BASE  ({32'h3000_0000}),
    .MASK  ({32'hF000_0000})
  ) u_dut1 (
    .clock   (clock),
    .reset   (reset),
    .axi     (up1),
    .axi_sub (sub1)
  );

  // Subordinate-side drive values and observed outputs of the 2-port DUT.
  logic [1:0]       s2_arready, s2_rvalid, s2_rlast, s2_awready, s2_wready, s2_bvalid;
  logic [1:0][31:0] s2_rdata;
  logic [1:0][1:0]  s2_rresp, s2_bresp;
  logic [1:0][3:0]  s2_rid, s2_bid;
  logic [1:0]       m2_arvalid, m2_rready, m2_awvalid, m2_wvalid, m2_wlast, m2_bready;
  logic [1:0][31:0] m2_araddr, m2_awaddr, m2_wdata;
  logic [1:0][3:0]  m2_wstrb;

  for (genvar g = 0; g < 2; g++) begin : g_sub2
    assign sub2[g].arready = s2_arready[g];
    assign sub2[g].rvalid  = s2_rvalid[g];
    assign sub2[g].rdata   = s2_rdata[g];
    assign sub2[g].rresp   = s2_rresp[g];
    assign sub2[g].rlast   = s2_rlast[g];
    assign sub2[g].rid     = s2_rid[g];
    assign sub2[g].awready = s2_awready[g];
    assign sub2[g].wready  = s2_wready[g];
    assign sub2[g].bvalid  = s2_bvalid[g];
    assign sub2[g].bresp   = s2_bresp[g];
    assign sub2[g].bid     = s2_bid[g];
    assign m2_arvalid[g]   = sub2[g].arvalid;
    assign m2_araddr[g]    = sub2[g].araddr;
    assign m2_rready[g]    = sub2[g].rready;
    assign m2_awvalid[g]   = sub2[g].awvalid;
    assign m2_awaddr[g]    = sub2[g].awaddr;
    assign m2_wvalid[g]    = sub2[g].wvalid;
    assign m2_wdata[g]     = sub2[g].wdata;
    assign m2_wstrb[g]     = sub2[g].wstrb;
    assign m2_wlast[g]     = sub2[g].wlast;
    assign m2_bready[g]    = sub2[g].bready;
  end

  // The 1-port DUT's only subordinate never answers; it must never be asked.
  assign sub1[0].arready = 1'b0;
  assign sub1[0].rvalid  = 1'b0;
  assign sub1[0].rdata   = '0;
  assign sub1[0].rresp   = '0;
  assign sub1[0].rlast   = 1'b0;
  assign sub1[0].rid     = '0;
  assign sub1[0].awready = 1'b0;
  assign sub1[0].wready  = 1'b0;
  assign sub1[0].bvalid  = 1'b0;
  assign sub1[0].bresp   = '0;
  assign sub1[0].bid     = '0;

  logic s1_seen = 1'b0;
  // Sticky flag: any downstream request from the 1-port DUT.
  always @(negedge clock) if (sub1[0].arvalid || sub1[0].awvalid) s1_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int  beats, last_at, rbeat, wphase;
  bit  rdone, r_hs, w_hs, b_hs;

  initial begin
    up2.arvalid = 0; up2.araddr = 0; up2.arid = 0; up2.arlen = 0; up2.arsize = 3'd2; up2.arburst = 2'd1;
    up2.rready = 0; up2.awvalid = 0; up2.awaddr = 0; up2.awid = 0; up2.awlen = 0; up2.awsize = 3'd2;
    up2.awburst = 2'd1; up2.wvalid = 0; up2.wdata = 0; up2.wstrb = 0; up2.wlast = 0; up2.bready = 0;
    up1.arvalid = 0; up1.araddr = 0; up1.arid = 0; up1.arlen = 0; up1.arsize = 3'd2; up1.arburst = 2'd1;
    up1.rready = 0; up1.awvalid = 0; up1.awaddr = 0; up1.awid = 0; up1.awlen = 0; up1.awsize = 3'd2;
    up1.awburst = 2'd1; up1.wvalid = 0; up1.wdata = 0; up1.wstrb = 0; up1.wlast = 0; up1.bready = 0;
    s2_arready = '0; s2_rvalid = '0; s2_rlast = '0; s2_awready = '0; s2_wready = '0; s2_bvalid = '0;
    s2_rdata = '0; s2_rresp = '0; s2_bresp = '0; s2_rid = '0; s2_bid = '0;

    // ---- reset values
    step(); step();
    chk("rst_arready", up2.arready, 1);
    chk("rst_awready", up2.awready, 1);
    chk("rst_rvalid", up2.rvalid, 0);
    chk("rst_bvalid", up2.bvalid, 0);
    chk("rst_wready", up2.wready, 0);
    chk("rst_sub_valids", {m2_arvalid, m2_awvalid, m2_wvalid, m2_rready, m2_bready}, 0);
    chk("rst_rdata", up2.rdata, 0);
    reset = 0;
    step();

    // ---- read routed to port 1
    up2.arvalid = 1; up2.araddr = 32'h0200_BFF8; up2.arid = 4'h5; up2.arlen = 8'd0;
    #1;
    chk("rd_arready_idle", up2.arready, 1);
    step();
    up2.arvalid = 0;
    #1;
    chk("rd_arvalid_t1", m2_arvalid, 2'b10);
    chk("rd_araddr", m2_araddr[1], 32'h0200_BFF8);
    chk("rd_arready_busy", up2.arready, 0);
    s2_arready[1] = 1;
    step();
    s2_arready[1] = 0; s2_rvalid[1] = 1; s2_rdata[1] = 32'h1234; s2_rresp[1] = 2'b00;
    s2_rlast[1] = 1; s2_rid[1] = 4'h5; up2.rready = 1;
    #1;
    chk("rd_rvalid", up2.rvalid, 1);
    chk("rd_rdata", up2.rdata, 32'h1234);
    chk("rd_rresp", up2.rresp, 0);
    chk("rd_rlast", up2.rlast, 1);
    chk("rd_rid", up2.rid, 5);
    chk("rd_rready_fwd", m2_rready, 2'b10);
    chk("rd_port0_idle", {m2_arvalid[0], m2_rready[0]}, 0);
    step();
    s2_rvalid[1] = 0; s2_rlast[1] = 0; up2.rready = 0;
    #1;
    chk("rd_back_idle", up2.arready, 1);

    // ---- write falls back to port 0; W presented before AW
    up2.awvalid = 1; up2.awaddr = 32'h8000_0000; up2.awid = 4'h3; up2.awlen = 8'd0;
    up2.wvalid = 1; up2.wdata = 32'hDEAD_BEEF; up2.wstrb = 4'hF; up2.wlast = 1;
    #1;
    chk("wr_no_early_wready", up2.wready, 0);
    step();
    up2.awvalid = 0;
    #1;
    chk("wr_awvalid", m2_awvalid, 2'b01);
    chk("wr_awaddr", m2_awaddr[0], 32'h8000_0000);
    chk("wr_wready_in_addr", up2.wready, 0);
    chk("wr_wvalid_in_addr", m2_wvalid, 0);
    s2_awready[0] = 1;
    step();
    s2_awready[0] = 0; s2_wready[0] = 1;
    #1;
    chk("wr_wvalid", m2_wvalid, 2'b01);
    chk("wr_wdata", m2_wdata[0], 32'hDEAD_BEEF);
    chk("wr_wstrb_wlast", {m2_wstrb[0], m2_wlast[0]}, 5'h1F);
    chk("wr_wready_fwd", up2.wready, 1);
    step();
    up2.wvalid = 0; up2.wlast = 0; s2_wready[0] = 0;
    s2_bvalid[0] = 1; s2_bresp[0] = 2'b00; s2_bid[0] = 4'h3; up2.bready = 1;
    #1;
    chk("wr_bvalid", up2.bvalid, 1);
    chk("wr_bid", up2.bid, 3);
    chk("wr_bresp", up2.bresp, 0);
    chk("wr_bready_fwd", m2_bready, 2'b01);
    step();
    s2_bvalid[0] = 0; up2.bready = 0;
    #1;
    chk("wr_bvalid_once", up2.bvalid, 0);
    chk("wr_back_idle", up2.awready, 1);

    // ---- DECERR read, arlen=3, with one rready stall
    up1.arvalid = 1; up1.araddr = 32'h8000_0000; up1.arid = 4'h9; up1.arlen = 8'd3;
    step();
    up1.arvalid = 0;
    #1;
    chk("erd_rvalid_t1", up1.rvalid, 1);
    chk("erd_rresp", up1.rresp, 2'b11);
    chk("erd_rid", up1.rid, 9);
    chk("erd_rdata", up1.rdata, 0);
    beats = 0; last_at = 0;
    for (int k = 0; k < 12; k++) begin
      up1.rready = (k != 1);
      if (up1.rvalid && up1.rready) begin
        beats++;
        if (up1.rlast && last_at == 0) last_at = beats;
      end
      step(); #1;
    end
    up1.rready = 0;
    chk("erd_beats", beats, 4);
    chk("erd_rlast_beat", last_at, 4);
    chk("erd_idle", up1.arready, 1);

    // ---- DECERR read, arlen=255 yields 256 beats
    up1.arvalid = 1; up1.arid = 4'hA; up1.arlen = 8'd255;
    step();
    up1.arvalid = 0; up1.rready = 1;
    beats = 0; last_at = 0;
    for (int k = 0; k < 270; k++) begin
      #1;
      if (up1.rvalid) begin
        beats++;
        if (up1.rlast && last_at == 0) last_at = beats;
      end
      step();
    end
    up1.rready = 0;
    chk("erd256_beats", beats, 256);
    chk("erd256_rlast", last_at, 256);

    // ---- DECERR write, two beats absorbed
    up1.awvalid = 1; up1.awaddr = 32'h8000_0000; up1.awid = 4'h6; up1.awlen = 8'd1;
    up1.wvalid = 1; up1.wdata = 32'h1; up1.wstrb = 4'hF; up1.wlast = 0;
    #1;
    chk("ewr_no_early_wready", up1.wready, 0);
    step();
    up1.awvalid = 0;
    #1;
    chk("ewr_wready_t1", up1.wready, 1);
    chk("ewr_awready_busy", up1.awready, 0);
    step();
    up1.wdata = 32'h2; up1.wlast = 1;
    #1;
    chk("ewr_wready_beat2", up1.wready, 1);
    chk("ewr_no_bvalid_yet", up1.bvalid, 0);
    step();
    up1.wvalid = 0; up1.wlast = 0;
    #1;
    chk("ewr_bvalid", up1.bvalid, 1);
    chk("ewr_bresp", up1.bresp, 2'b11);
    chk("ewr_bid", up1.bid, 6);
    chk("ewr_wready_closed", up1.wready, 0);
    up1.bready = 1;
    step();
    up1.bready = 0;
    #1;
    chk("ewr_idle", {up1.awready, up1.bvalid}, 2'b10);
    chk("e_no_downstream", s1_seen, 0);

    // ---- concurrent read (port 1) and write (port 0) with random stalls
    up2.arvalid = 1; up2.araddr = 32'h0200_0004; up2.arid = 4'h1; up2.arlen = 8'd1;
    up2.awvalid = 1; up2.awaddr = 32'h0000_1000; up2.awid = 4'h2; up2.awlen = 8'd0;
    up2.wvalid = 1; up2.wdata = 32'hCAFE_0001; up2.wstrb = 4'hF; up2.wlast = 1;
    s2_arready[1] = 1; s2_awready[0] = 1;
    step();
    up2.arvalid = 0; up2.awvalid = 0;
    #1;
    chk("conc_arvalid", m2_arvalid, 2'b10);
    chk("conc_awvalid", m2_awvalid, 2'b01);
    step();
    s2_arready = '0; s2_awready = '0; s2_wready[0] = 1;
    rbeat = 0; rdone = 0; wphase = 0;
    for (int k = 0; k < 80 && !(rdone && wphase == 2); k++) begin
      up2.rready = 1'($urandom_range(0, 1));
      up2.bready = 1'($urandom_range(0, 1));
      s2_rvalid[1] = !rdone; s2_rdata[1] = 32'hA000_0000 + 32'(rbeat);
      s2_rlast[1] = (rbeat == 1); s2_rid[1] = 4'h1; s2_rresp[1] = 2'b00;
      s2_bvalid[0] = (wphase == 1); s2_bid[0] = 4'h2; s2_bresp[0] = 2'b00;
      #1;
      if (!rdone) chk("conc_arready_low", up2.arready, 0);
      r_hs = up2.rvalid && up2.rready;
      w_hs = (wphase == 0) && up2.wvalid && up2.wready;
      b_hs = (wphase == 1) && up2.bvalid && up2.bready;
      if (r_hs) begin
        chk("conc_rdata", up2.rdata, 32'hA000_0000 + 32'(rbeat));
        chk("conc_rlast", up2.rlast, 32'(rbeat == 1));
      end
      if (w_hs) chk("conc_wdata", m2_wdata[0], 32'hCAFE_0001);
      if (b_hs) chk("conc_bid", up2.bid, 2);
      step();
      if (r_hs) begin
        if (rbeat == 1) rdone = 1;
        rbeat++;
      end
      if (w_hs) begin
        wphase = 1; up2.wvalid = 0; up2.wlast = 0; s2_wready[0] = 0;
      end
      if (b_hs) wphase = 2;
    end
    up2.rready = 0; up2.bready = 0; s2_rvalid = '0; s2_rlast = '0; s2_bvalid = '0;
    chk("conc_rd_done", rdone, 1);
    chk("conc_wr_done", wphase, 2);
    chk("conc_arready_after", up2.arready, 1);

    // ---- reset while in R_DATA, then a fresh read
    up2.arvalid = 1; up2.araddr = 32'h0200_0000; up2.arid = 4'h7; up2.arlen = 8'd3;
    step();
    up2.arvalid = 0; s2_arready[1] = 1;
    step();
    s2_arready[1] = 0; s2_rvalid[1] = 1; s2_rdata[1] = 32'h5555_AAAA; s2_rlast[1] = 0;
    s2_rid[1] = 4'h7; up2.rready = 1;
    #1;
    chk("mid_rvalid", up2.rvalid, 1);
    reset = 1;
    step();
    chk("mid_rst_ready", {up2.arready, up2.awready}, 2'b11);
    chk("mid_rst_rvalid", up2.rvalid, 0);
    chk("mid_rst_rdata", up2.rdata, 0);
    chk("mid_rst_sub", {m2_arvalid, m2_rready}, 0);
    reset = 0; s2_rvalid = '0; up2.rready = 0;
    step();
    up2.arvalid = 1; up2.araddr = 32'h0200_0008; up2.arid = 4'h4; up2.arlen = 8'd0;
    step();
    up2.arvalid = 0; s2_arready[1] = 1;
    #1;
    chk("post_arvalid", m2_arvalid, 2'b10);
    chk("post_araddr", m2_araddr[1], 32'h0200_0008);
    step();
    s2_arready[1] = 0; s2_rvalid[1] = 1; s2_rdata[1] = 32'h0BAD_F00D; s2_rlast[1] = 1;
    s2_rid[1] = 4'h4; up2.rready = 1;
    #1;
    chk("post_rdata", up2.rdata, 32'h0BAD_F00D);
    chk("post_rid_rlast", {up2.rid, up2.rlast}, 5'h09);
    step();
    s2_rvalid = '0; s2_rlast = '0; up2.rready = 0;
    #1;
    chk("post_idle", up2.arready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24080006_axi_xbar.md
# ysyx_24080006_axi_xbar

Parametrised 1-to-N AXI4 address router that replaces the fixed two-way core/CLINT split. It sits between the core's AXI master interface and `N_SUB` downstream subordinates (SoC master port, CLINT, future local peripherals). Each transaction is routed by a base/mask match. Unmatched addresses are answered internally with DECERR, and the read and write paths each run an independent single-outstanding FSM.

## Interface
Parameters:
- `N_SUB`, default 2: number of downstream ports, legal range 1..8.
- `BASE`, default `{32'h0200_0000, 32'h0000_0000}`: per-port base address, array `[N_SUB]`.
- `MASK`, default `{32'hFFFF_0000, 32'h0000_0000}`: per-port match mask, array `[N_SUB]`. Port i matches when `(addr & MASK[i]) == (BASE[i] & MASK[i])`.

Ports:
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `axi`  `ysyx_24080006_axi` slave side  -: upstream interface from the core. Data is 32 bits and ID is 4 bits.
- `axi_sub[N_SUB]`  `ysyx_24080006_axi` master side  -: downstream interfaces. Index 0 is the lowest priority.

## Operation
- Decode rule: when several ports match, the highest index wins. A mask of all zeros therefore acts as the default/fallback port.
- Read FSM has four states: `R_IDLE`, `R_ADDR`, `R_DATA`, `R_ERR`.
  - `R_IDLE`: `axi.arready=1`. On an AR handshake, latch `araddr/arid/arlen/arsize/arburst` and the decoded index.
  - If a port matched, go to `R_ADDR`; otherwise go to `R_ERR`.
  - `R_ADDR`: drive `arvalid` and the latched fields to the selected port only. On downstream `arready`, go to `R_DATA`.
  - `R_DATA`: the R channel is combinationally connected between the selected port and upstream, and `rready` is forwarded. On `rvalid & rready & rlast`, go to `R_IDLE`.
  - `R_ERR`: generate `arlen+1` beats with `rresp=2'b11`, `rdata=0`, `rid` = latched ID, and `rlast` on the final beat. Each beat is held until `rready`. After the last beat, go to `R_IDLE`.
- Write FSM has five states: `W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`, `W_ERR`.
  - `W_IDLE`: `awready=1`. Latch the AW fields and the decoded index.
  - If a port matched, go to `W_ADDR`; otherwise go to `W_ERR`.
  - `W_ADDR`: drive `awvalid` to the selected port. On downstream `awready`, go to `W_DATA`.
  - `W_DATA`: the W channel is passed through to the selected port. On `wvalid & wready & wlast`, go to `W_RESP`.
  - `W_RESP`: the B channel is passed through from the selected port. On the handshake, go to `W_IDLE`.
  - `W_ERR`: hold `wready=1` and discard beats until `wlast`. Then drive `bvalid` with `bresp=2'b11` and the latched `bid` until `bready`, then go to `W_IDLE`.
- Non-selected ports: all their valid/ready outputs are 0 and their address/data outputs are 0.
- Upstream W before AW: `wready` stays 0 until `W_DATA` or `W_ERR`. W beats are never accepted early.
- Read and write paths may target the same or different ports concurrently. There is no cross-path interlock.
- Reset mid-transaction: both FSMs return to idle and all outputs go to their reset values. In-flight beats are abandoned; the system is reset as a whole.

## Timing
- Reset values:
  - `axi.arready=1`, `axi.awready=1`.
  - `axi.rvalid=0`, `axi.bvalid=0`, `axi.wready=0`.
  - All `axi_sub[*]` valids and readies are 0.
  - All data, ID and response outputs are 0.
- AR/AW added latency: 1 cycle. An upstream handshake in cycle T gives downstream `arvalid`/`awvalid` at T+1 and earliest.
- R, W and B pass-through adds 0 cycles of latency (combinational).
- Error read: first `rvalid` at T+1, one beat per cycle while `rready=1`.
- Error write: `wready` high from T+1. `bvalid` comes 1 cycle after the `wlast` handshake.
- Upstream `arready`/`awready` are 0 in every non-idle state. A new address is accepted no earlier than the cycle after the final R or B handshake.
- The error beat counter is 8 bits and counts down from `arlen`. `rlast` is asserted when the count reaches 0. `arlen=255` must produce exactly 256 beats.

## Structure
- Package `ysyx_24080006_xbar_pkg` holds:
  - typedefs `rd_state_e` and `wr_state_e`;
  - constants `RESP_OKAY=2'b00` and `RESP_DECERR=2'b11`;
  - constant `XBAR_MAX_SUB=8`.
- Sub-module `ysyx_24080006_xbar_decode` is a combinational address-to-{hit, index} decoder. It is instantiated twice, once for AR and once for AW.
- Target size is roughly 250 lines of RTL.

## Test plan
- Read routing: `N_SUB=2`, read at `0x0200_BFF8` with `arlen=0`.
  - `axi_sub[1].arvalid` rises at T+1.
  - Port 1 returns `0x1234` → upstream sees `rdata=0x1234`, `rresp=0`, `rlast=1`.
  - `axi_sub[0]` stays idle throughout.
- Write fallback: write to `0x8000_0000` with `wstrb=4'hF`, data `0xDEAD_BEEF`.
  - Port 0 receives AW, then W, and returns B `OKAY`.
  - Upstream `bvalid` is high for one handshake with `bid` = sent ID.
- Decode error, read: `N_SUB=1`, `MASK={32'hF000_0000}`, `BASE={32'h3000_0000}`, read at `0x8000_0000` with `arlen=3`.
  - Exactly 4 beats with `rresp=2'b11`, `rlast` on beat 4.
  - No downstream `arvalid`.
- Decode error, write: same configuration, 2-beat write.
  - Both beats absorbed.
  - `bresp=2'b11` one cycle after `wlast`.
- Concurrency and backpressure: read to port 1 and write to port 0 in the same cycle, random `rready`/`bready` stalls.
  - Both complete with correct data.
  - `arready` stays 0 until the read's `rlast` handshake.
- Reset during `R_DATA`:
  - All outputs hold their reset values the next cycle.
  - A fresh read completes normally afterwards.
